// File: rtl/vc_dest_arbiter.sv
// ---------------------------------------------------------------------------
// vc_dest_arbiter
//
// Sits behind the VC0/VC1 virtual-channel FIFOs. Each cycle it picks at most
// one VC head, routes the word by bit [4] into one of two internal
// destination FIFOs (D0/D1), and serves registered reads from those FIFOs.
//
// Word format (DATA_W = 6): [5] VC, [4] destination (0 -> D0, 1 -> D1),
// [3:0] payload.
//
// Ports:
//   clk, reset_L             clock, asynchronous active-low reset
//   init, umbral_D0/D1       latch almost-full thresholds (0 means DEPTH)
//   vc0_data/empty/pop       VC0 FIFO head (first-word-fall-through) + pop
//   vc1_data/empty/pop       VC1 FIFO head + pop
//   pop_D0/pop_D1            read requests for the destination FIFOs
//   data_out0/1, valid_out0/1  registered read data, one-cycle valid pulse
//   D0/D1_empty, D0/D1_almost_full  destination FIFO status
//   error_out                sticky pop-on-empty flag, cleared only by reset
//
// Build option: define VC_RR_ARB_EN for round-robin arbitration between the
// two VCs; otherwise VC0 has fixed priority.
// ---------------------------------------------------------------------------
module vc_dest_arbiter #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [1:0]        umbral_D0,
    input  logic [1:0]        umbral_D1,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic              vc0_empty,
    output logic              vc0_pop,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              vc1_empty,
    output logic              vc1_pop,
    input  logic              pop_D0,
    input  logic              pop_D1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              D0_empty,
    output logic              D1_empty,
    output logic              D0_almost_full,
    output logic              D1_almost_full,
    output logic              error_out
);

    localparam int CNT_W = ADDR_W + 1;

    logic [1:0]        pop_req;
    logic [1:0]        umbral_in [2];
    logic [1:0]        almost_full;
    logic [1:0]        empty;
    logic [1:0]        rd_err;
    logic [1:0]        dvalid;
    logic [DATA_W-1:0] dout [2];
    logic [DATA_W-1:0] wr_data;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              error_reg;

    assign pop_req      = {pop_D1, pop_D0};
    assign umbral_in[0] = umbral_D0;
    assign umbral_in[1] = umbral_D1;

    // A head may only go if its own target FIFO has room below threshold.
    assign elig0 = !vc0_empty && !almost_full[vc0_data[4]];
    assign elig1 = !vc1_empty && !almost_full[vc1_data[4]];

`ifdef VC_RR_ARB_EN
    // 1 = VC1 was granted last; resets to VC1 so VC0 wins the first tie.
    logic last_grant_reg;

    always_comb begin
        grant0 = elig0 && (!elig1 || last_grant_reg);
        grant1 = elig1 && (!elig0 || !last_grant_reg);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_grant_reg <= 1'b1;
        end else if (vc0_pop) begin
            last_grant_reg <= 1'b0;
        end else if (vc1_pop) begin
            last_grant_reg <= 1'b1;
        end
    end
`else
    always_comb begin
        grant0 = elig0;
        grant1 = elig1 && !elig0;
    end
`endif

    // Pops are forced low while reset is held, independent of the clock.
    assign vc0_pop = reset_L && grant0;
    assign vc1_pop = reset_L && grant1;
    assign wr_data = vc0_pop ? vc0_data : vc1_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dest
            logic [DATA_W-1:0] mem [DEPTH];
            logic [ADDR_W-1:0] wr_ptr_reg;
            logic [ADDR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;
            logic [CNT_W-1:0]  count_next;
            logic [CNT_W-1:0]  thr_eff;
            logic [1:0]        thr_reg;
            logic [DATA_W-1:0] data_out_reg;
            logic              valid_reg;
            logic              wr;
            logic              rd;

            // Threshold code 0 stands for a completely full FIFO.
            assign thr_eff = (thr_reg == 2'd0) ? CNT_W'(DEPTH) : CNT_W'(thr_reg);

            assign wr = (vc0_pop && (vc0_data[4] == 1'(gi))) ||
                        (vc1_pop && (vc1_data[4] == 1'(gi)));
            // Reads only ever see stored words; an empty FIFO never
            // forwards a same-cycle write.
            assign rd = pop_req[gi] && (count_reg != '0);

            assign count_next      = count_reg + CNT_W'(wr) - CNT_W'(rd);
            assign almost_full[gi] = (count_reg >= thr_eff);
            assign empty[gi]       = (count_reg == '0);
            assign rd_err[gi]      = pop_req[gi] && (count_reg == '0);
            assign dvalid[gi]      = valid_reg;
            assign dout[gi]        = data_out_reg;

            // Storage needs no reset: clearing the pointers discards it.
            always_ff @(posedge clk) begin
                if (wr) begin
                    mem[wr_ptr_reg] <= wr_data;
                end
            end

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    thr_reg      <= 2'd3;
                    data_out_reg <= '0;
                    valid_reg    <= 1'b0;
                end else begin
                    if (init) begin
                        thr_reg <= umbral_in[gi];
                    end
                    if (wr) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (rd) begin
                        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                        data_out_reg <= mem[rd_ptr_reg];
                    end
                    valid_reg <= rd;
                    count_reg <= count_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_reg <= 1'b0;
        end else if (|rd_err) begin
            error_reg <= 1'b1;
        end
    end

    assign data_out0      = dout[0];
    assign data_out1      = dout[1];
    assign valid_out0     = dvalid[0];
    assign valid_out1     = dvalid[1];
    assign D0_empty       = empty[0];
    assign D1_empty       = empty[1];
    assign D0_almost_full = almost_full[0];
    assign D1_almost_full = almost_full[1];
    assign error_out      = error_reg;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vc_dest_arbiter
//
// Directed bench for vc_dest_arbiter. The two upstream VC FIFOs are modelled
// as queues whose heads are presented first-word-fall-through; a head leaves
// its queue when the DUT pops it at a rising edge. Inputs change and outputs
// are sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_vc_dest_arbiter;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [1:0] umbral_D0;
    logic [1:0] umbral_D1;
    logic [5:0] vc0_data;
    logic       vc0_empty;
    logic       vc0_pop;
    logic [5:0] vc1_data;
    logic       vc1_empty;
    logic       vc1_pop;
    logic       pop_D0;
    logic       pop_D1;
    logic [5:0] data_out0;
    logic [5:0] data_out1;
    logic       valid_out0;
    logic       valid_out1;
    logic       D0_empty;
    logic       D1_empty;
    logic       D0_almost_full;
    logic       D1_almost_full;
    logic       error_out;

    int passed = 0;
    int total  = 0;

    logic [5:0] vq0 [$];
    logic [5:0] vq1 [$];
    logic       last_g0;
    logic       last_g1;

    always #5 clk = ~clk;

    vc_dest_arbiter dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .umbral_D0      (umbral_D0),
        .umbral_D1      (umbral_D1),
        .vc0_data       (vc0_data),
        .vc0_empty      (vc0_empty),
        .vc0_pop        (vc0_pop),
        .vc1_data       (vc1_data),
        .vc1_empty      (vc1_empty),
        .vc1_pop        (vc1_pop),
        .pop_D0         (pop_D0),
        .pop_D1         (pop_D1),
        .data_out0      (data_out0),
        .data_out1      (data_out1),
        .valid_out0     (valid_out0),
        .valid_out1     (valid_out1),
        .D0_empty       (D0_empty),
        .D1_empty       (D1_empty),
        .D0_almost_full (D0_almost_full),
        .D1_almost_full (D1_almost_full),
        .error_out      (error_out)
    );

    task automatic drive_heads();
        vc0_empty = (vq0.size() == 0);
        vc0_data  = (vq0.size() != 0) ? vq0[0] : 6'h00;
        vc1_empty = (vq1.size() == 0);
        vc1_data  = (vq1.size() != 0) ? vq1[0] : 6'h00;
    endtask

    // One clock cycle: record the grants just before the edge, retire the
    // popped heads at the edge, and return 1 time unit after the falling edge.
    task automatic tick();
        drive_heads();
        #1;
        last_g0 = vc0_pop;
        last_g1 = vc1_pop;
        @(posedge clk);
        if (last_g0 && vq0.size() != 0) void'(vq0.pop_front());
        if (last_g1 && vq1.size() != 0) void'(vq1.pop_front());
        @(negedge clk);
        drive_heads();
        #1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0; init = 1'b0; pop_D0 = 1'b0; pop_D1 = 1'b0;
        umbral_D0 = 2'd0; umbral_D1 = 2'd0;
        vq0.delete(); vq1.delete();
        vq0.push_back(6'h01);
        drive_heads();
        repeat (2) @(negedge clk);
        #1;
        total++; if (D0_empty !== 1'b1) $display("FAIL rst_d0_empty: got %b want 1", D0_empty); else passed++;
        total++; if (D1_empty !== 1'b1) $display("FAIL rst_d1_empty: got %b want 1", D1_empty); else passed++;
        total++; if ({D1_almost_full, D0_almost_full} !== 2'b00) $display("FAIL rst_almost_full: got %b want 00", {D1_almost_full, D0_almost_full}); else passed++;
        total++; if (error_out !== 1'b0) $display("FAIL rst_error: got %b want 0", error_out); else passed++;
        total++; if ({data_out1, data_out0} !== 12'h000) $display("FAIL rst_data: got %h want 000", {data_out1, data_out0}); else passed++;
        total++; if ({valid_out1, valid_out0} !== 2'b00) $display("FAIL rst_valid: got %b want 00", {valid_out1, valid_out0}); else passed++;
        total++; if (vc0_pop !== 1'b0) $display("FAIL rst_vc0_pop: got %b want 0", vc0_pop); else passed++;
        vq0.delete();
        drive_heads();
        reset_L = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_first_grants();
        vq0.push_back(6'h1B);
        vq1.push_back(6'h2D);
        init = 1'b1; umbral_D0 = 2'd2; umbral_D1 = 2'd3;
        tick();
        init = 1'b0;
        total++; if ({last_g1, last_g0} !== 2'b01) $display("FAIL grant_c1: got vc1/vc0=%b want 01", {last_g1, last_g0}); else passed++;
        total++; if ({D1_empty, D0_empty} !== 2'b01) $display("FAIL route_1b_to_d1: got D1/D0 empty=%b want 01", {D1_empty, D0_empty}); else passed++;
        tick();
        total++; if ({last_g1, last_g0} !== 2'b10) $display("FAIL grant_c2: got vc1/vc0=%b want 10", {last_g1, last_g0}); else passed++;
        total++; if ({D1_empty, D0_empty} !== 2'b00) $display("FAIL both_nonempty: got D1/D0 empty=%b want 00", {D1_empty, D0_empty}); else passed++;
        pop_D0 = 1'b1; pop_D1 = 1'b1;
        tick();
        pop_D0 = 1'b0; pop_D1 = 1'b0;
        total++; if (data_out0 !== 6'h2D || valid_out0 !== 1'b1) $display("FAIL first_read_d0: got %h/%b want 2d/1", data_out0, valid_out0); else passed++;
        total++; if (data_out1 !== 6'h1B || valid_out1 !== 1'b1) $display("FAIL first_read_d1: got %h/%b want 1b/1", data_out1, valid_out1); else passed++;
        tick();
        total++; if ({valid_out1, valid_out0} !== 2'b00) $display("FAIL valid_pulse: got %b want 00", {valid_out1, valid_out0}); else passed++;
    endtask

    task automatic test_almost_full();
        vq0.push_back(6'h01); vq0.push_back(6'h02); vq0.push_back(6'h03);
        tick();
        tick();
        total++; if (D0_almost_full !== 1'b1) $display("FAIL af_d0_set: got %b want 1", D0_almost_full); else passed++;
        total++; if (vc0_pop !== 1'b0) $display("FAIL af_vc0_blocked: got %b want 0", vc0_pop); else passed++;
        vq1.push_back(6'h3A);
        tick();
        total++; if ({last_g1, last_g0} !== 2'b10) $display("FAIL af_vc1_granted: got vc1/vc0=%b want 10", {last_g1, last_g0}); else passed++;
        total++; if (vq0.size() !== 1) $display("FAIL af_vc0_left: got %0d want 1", vq0.size()); else passed++;
        vq0.delete();
        pop_D0 = 1'b1; pop_D1 = 1'b1;
        tick();
        pop_D1 = 1'b0;
        total++; if (data_out0 !== 6'h01 || data_out1 !== 6'h3A) $display("FAIL af_drain1: got %h/%h want 01/3a", data_out0, data_out1); else passed++;
        tick();
        pop_D0 = 1'b0;
        total++; if (data_out0 !== 6'h02 || valid_out0 !== 1'b1) $display("FAIL af_drain2: got %h/%b want 02/1", data_out0, valid_out0); else passed++;
    endtask

    task automatic test_read();
        vq0.push_back(6'h0A); vq0.push_back(6'h0B);
        tick();
        tick();
        pop_D0 = 1'b1;
        tick();
        total++; if (data_out0 !== 6'h0A || valid_out0 !== 1'b1) $display("FAIL read_0a: got %h/%b want 0a/1", data_out0, valid_out0); else passed++;
        tick();
        pop_D0 = 1'b0;
        total++; if (data_out0 !== 6'h0B || valid_out0 !== 1'b1) $display("FAIL read_0b: got %h/%b want 0b/1", data_out0, valid_out0); else passed++;
        total++; if (D0_empty !== 1'b1) $display("FAIL read_d0_empty: got %b want 1", D0_empty); else passed++;
        total++; if (error_out !== 1'b0) $display("FAIL read_no_error: got %b want 0", error_out); else passed++;
    endtask

    task automatic test_pop_empty();
        pop_D1 = 1'b1;
        tick();
        pop_D1 = 1'b0;
        total++; if (valid_out1 !== 1'b0) $display("FAIL empty_pop_valid: got %b want 0", valid_out1); else passed++;
        total++; if (error_out !== 1'b1) $display("FAIL empty_pop_error: got %b want 1", error_out); else passed++;
        total++; if (data_out1 !== 6'h3A) $display("FAIL empty_pop_hold: got %h want 3a", data_out1); else passed++;
        repeat (3) tick();
        total++; if (error_out !== 1'b1) $display("FAIL error_sticky: got %b want 1", error_out); else passed++;
    endtask

    task automatic test_wrap_full();
        init = 1'b1; umbral_D0 = 2'd0; umbral_D1 = 2'd3;
        tick();
        init = 1'b0;
        for (int i = 1; i <= 6; i++) vq0.push_back(6'(i));
        repeat (5) tick();
        total++; if (D0_almost_full !== 1'b1) $display("FAIL full_af: got %b want 1", D0_almost_full); else passed++;
        total++; if (vq0.size() !== 2) $display("FAIL full_stall: got %0d words left want 2", vq0.size()); else passed++;
        pop_D0 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++; if (data_out0 !== 6'(i) || valid_out0 !== 1'b1) $display("FAIL wrap_order_%0d: got %h/%b want %h/1", i, data_out0, valid_out0, 6'(i)); else passed++;
        end
        pop_D0 = 1'b0;
        total++; if (D0_empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", D0_empty); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) vq0.push_back(6'(i));
        repeat (3) tick();
        pop_D0 = 1'b1;
        tick();
        pop_D0 = 1'b0;
        total++; if (data_out0 !== 6'h01) $display("FAIL pre_rst_data: got %h want 01", data_out0); else passed++;
        vq0.push_back(6'h05);
        drive_heads();
        #1;
        total++; if (vc0_pop !== 1'b1) $display("FAIL pre_rst_pop: got %b want 1", vc0_pop); else passed++;
        reset_L = 1'b0;
        #1;
        total++; if (D0_empty !== 1'b1) $display("FAIL async_rst_empty: got %b want 1", D0_empty); else passed++;
        total++; if (data_out0 !== 6'h00) $display("FAIL async_rst_data: got %h want 00", data_out0); else passed++;
        total++; if (vc0_pop !== 1'b0) $display("FAIL async_rst_pop: got %b want 0", vc0_pop); else passed++;
        total++; if (error_out !== 1'b0) $display("FAIL async_rst_error: got %b want 0", error_out); else passed++;
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        vq0.push_back(6'h06); vq0.push_back(6'h07); vq0.push_back(6'h08);
        repeat (4) tick();
        total++; if (D0_almost_full !== 1'b1 || vq0.size() !== 1) $display("FAIL rst_threshold3: got af=%b left=%0d want 1/1", D0_almost_full, vq0.size()); else passed++;
        vq0.delete();
        drive_heads();
    endtask

    task automatic test_arbitration_order();
        logic exp_g0;
        reset_L = 1'b0;
        #1;
        reset_L = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            vq0.push_back(6'h01 + 6'(i));
            vq1.push_back(6'h31 + 6'(i));
        end
        pop_D0 = 1'b1; pop_D1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef VC_RR_ARB_EN
            exp_g0 = (i % 2 == 0);
`else
            exp_g0 = 1'b1;
`endif
            total++; if ({last_g1, last_g0} !== {~exp_g0, exp_g0}) $display("FAIL grant_order_%0d: got vc1/vc0=%b want %b", i, {last_g1, last_g0}, {~exp_g0, exp_g0}); else passed++;
        end
        pop_D0 = 1'b0; pop_D1 = 1'b0;
        vq0.delete(); vq1.delete();
        drive_heads();
    endtask

    initial begin
        test_reset();
        test_first_grants();
        test_almost_full();
        test_read();
        test_pop_empty();
        test_wrap_full();
        test_async_reset();
        test_arbitration_order();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
